// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with registered read port, occupancy flags and sticky errors.
// Optional dup/swap operations are compiled in when STACK_DUP_SWAP_EN is defined.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
`ifdef STACK_DUP_SWAP_EN
  input  logic             dup,
  input  logic             swap,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             zero,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_a;
  logic [AW-1:0]    next_a;
  logic             replace, push_ok, push_rej, pop_ok, rd_ok, rd_rej;
  logic             inc, ovf_set, unf_set;

  assign top_a  = AW'(count - CW'(1));
  assign next_a = AW'(count);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign zero   = (dout == '0);

  // push+pop on a non-empty stack overwrites the top, so it is legal even when full
  assign replace  = push & pop & ~empty;
  assign push_ok  = push & ~replace & ~full;
  assign push_rej = push & ~replace & full;
  assign pop_ok   = pop & ~push & ~empty;
  assign rd_ok    = (pop | tos) & ~empty;
  assign rd_rej   = (pop | tos) & empty;

`ifdef STACK_DUP_SWAP_EN
  logic          ops_idle, dup_v, swap_v, dup_ok, swap_ok;
  logic [AW-1:0] below_a;

  assign below_a  = AW'(count - CW'(2));
  assign ops_idle = ~(push | pop | tos);
  assign dup_v    = dup & ops_idle;
  assign swap_v   = swap & ~dup & ops_idle;
  assign dup_ok   = dup_v & ~empty & ~full;
  assign swap_ok  = swap_v & (count >= CW'(2));
  assign inc      = push_ok | dup_ok;
  assign ovf_set  = push_rej | (dup_v & full);
  assign unf_set  = rd_rej | (dup_v & empty) | (swap_v & (count < CW'(2)));
`else
  assign inc      = push_ok;
  assign ovf_set  = push_rej;
  assign unf_set  = rd_rej;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[next_a] <= din;
    end else if (replace) begin
      mem[top_a] <= din;
    end
`ifdef STACK_DUP_SWAP_EN
    else if (dup_ok) begin
      mem[next_a] <= mem[top_a];
    end else if (swap_ok) begin
      mem[top_a]   <= mem[below_a];
      mem[below_a] <= mem[top_a];
    end
`endif
  end

  // Errors are sticky; a new error in the same cycle as clr_err keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (inc) begin
        count <= count + CW'(1);
      end else if (pop_ok) begin
        count <= count - CW'(1);
      end
      dout_valid <= rd_ok;
      if (rd_ok) begin
        dout <= mem[top_a];
      end
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule
